// File: rtl/simon_autoplayer_if.sv
// ============================================================================
// Module      : simon_autoplayer_if
// Description : Pad-side bundle between the Simon game and its autoplayer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface simon_autoplayer_if;
    logic       en;
    logic [3:0] colour_led;
    logic [1:0] state_dbg;
    logic       mistake;
    logic [3:0] button;
    logic       busy;
    logic [4:0] seq_count;
    logic       replay_done;
    logic       overflow;
    logic       bad_colour;

    // master is the autoplayer; slave is the game/bench side
    modport master (
        input  en, colour_led, state_dbg, mistake,
        output button, busy, seq_count, replay_done, overflow, bad_colour
    );

    modport slave (
        output en, colour_led, state_dbg, mistake,
        input  button, busy, seq_count, replay_done, overflow, bad_colour
    );
endinterface

`default_nettype wire

// File: rtl/simon_autoplayer.sv
// ============================================================================
// Module      : simon_autoplayer
// Description : Records the colours a Simon game displays and replays them
//               as timed one-hot button presses, optionally corrupting the last.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simon_autoplayer #(
    parameter int PRESS_CYCLES = 4,
    parameter int GAP_CYCLES   = 4
) (
    input  logic               clk,
    input  logic               rst,
    simon_autoplayer_if.master pad
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_CAPTURE = 3'd1;
    localparam logic [2:0] c_PRESS   = 3'd2;
    localparam logic [2:0] c_GAP     = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;

    localparam logic [1:0] c_DBG_DISPLAY = 2'b01;
    localparam logic [1:0] c_DBG_WAIT    = 2'b10;

    localparam int c_TMR_MAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    localparam logic [c_TMR_W-1:0] c_PRESS_LAST = c_TMR_W'(PRESS_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_GAP_LAST   = c_TMR_W'(GAP_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ZERO   = '0;
    localparam logic [c_TMR_W-1:0] c_TMR_ONE    = c_TMR_W'(1);

    logic [2:0]         r_state;
    logic [3:0]         r_prev_led;
    logic [1:0]         r_buf [16];
    logic [4:0]         r_count;
    logic [3:0]         r_idx;
    logic [c_TMR_W-1:0] r_timer;
    logic               r_mistake;
    logic               r_overflow;
    logic               r_bad_colour;
    logic [3:0]         r_button;
    logic               r_replay_done;

    logic [2:0]         w_state_nxt;
    logic [4:0]         w_count_nxt;
    logic [3:0]         w_idx_nxt;
    logic [c_TMR_W-1:0] w_timer_nxt;
    logic               w_mistake_nxt;
    logic               w_overflow_nxt;
    logic               w_bad_nxt;
    logic               w_wr_en;
    logic [3:0]         w_wr_addr;
    logic [1:0]         w_rd_code;
    logic [1:0]         w_press_code;
    logic               w_last_nxt;
    logic [3:0]         w_button_nxt;

    logic w_onehot;
    logic w_multi;
    logic w_new;
    logic w_last;
    logic w_dbg_wait;

    function automatic logic [1:0] f_encode(input logic [3:0] v);
        logic [1:0] code;
        code = 2'd0;
        case (v)
            4'b0010: code = 2'd1;
            4'b0100: code = 2'd2;
            4'b1000: code = 2'd3;
            default: code = 2'd0;
        endcase
        return code;
    endfunction

    // A held colour never re-triggers; a repeat needs a blank sample in between
    assign w_onehot   = (pad.colour_led != 4'b0000) &&
                        ((pad.colour_led & (pad.colour_led - 4'd1)) == 4'b0000);
    assign w_multi    = (pad.colour_led != 4'b0000) && !w_onehot;
    assign w_new      = w_onehot && (pad.colour_led != r_prev_led);
    assign w_last     = ({1'b0, r_idx} == (r_count - 5'd1));
    assign w_dbg_wait = (pad.state_dbg == c_DBG_WAIT);

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_idx_nxt      = r_idx;
        w_timer_nxt    = r_timer;
        w_mistake_nxt  = r_mistake;
        w_overflow_nxt = r_overflow;
        w_bad_nxt      = r_bad_colour;
        w_wr_en        = 1'b0;
        w_wr_addr      = r_count[3:0];

        if (!pad.en) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (pad.state_dbg == c_DBG_DISPLAY) begin
                        w_state_nxt    = c_CAPTURE;
                        w_count_nxt    = 5'd0;
                        w_overflow_nxt = 1'b0;
                        w_bad_nxt      = w_multi;
                        if (w_new) begin
                            w_wr_en     = 1'b1;
                            w_wr_addr   = 4'd0;
                            w_count_nxt = 5'd1;
                        end
                    end else if (w_multi) begin
                        w_bad_nxt = 1'b1;
                    end
                end
                c_CAPTURE: begin
                    if (w_multi) begin
                        w_bad_nxt = 1'b1;
                    end
                    if (w_new) begin
                        if (r_count == 5'd16) begin
                            w_overflow_nxt = 1'b1;
                        end else begin
                            w_wr_en     = 1'b1;
                            w_count_nxt = r_count + 5'd1;
                        end
                    end
                    if (w_dbg_wait) begin
                        if (r_count != 5'd0) begin
                            w_state_nxt   = c_PRESS;
                            w_idx_nxt     = 4'd0;
                            w_timer_nxt   = c_TMR_ZERO;
                            w_mistake_nxt = pad.mistake;
                        end else begin
                            w_state_nxt = c_DONE;
                        end
                    end
                end
                c_PRESS: begin
                    if (!w_dbg_wait) begin
                        w_state_nxt = c_IDLE;
                    end else if (r_timer == c_PRESS_LAST) begin
                        w_state_nxt = c_GAP;
                        w_timer_nxt = c_TMR_ZERO;
                    end else begin
                        w_timer_nxt = r_timer + c_TMR_ONE;
                    end
                end
                c_GAP: begin
                    if (!w_dbg_wait) begin
                        w_state_nxt = c_IDLE;
                    end else if (r_timer == c_GAP_LAST) begin
                        w_timer_nxt = c_TMR_ZERO;
                        if (w_last) begin
                            w_state_nxt = c_DONE;
                        end else begin
                            w_idx_nxt   = r_idx + 4'd1;
                            w_state_nxt = c_PRESS;
                        end
                    end else begin
                        w_timer_nxt = r_timer + c_TMR_ONE;
                    end
                end
                c_DONE: begin
                    if (!w_dbg_wait) begin
                        w_state_nxt = c_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                end
            endcase
        end
    end

    // Button is registered from next-state so it is valid the cycle after the decision
    always_comb begin
        w_rd_code    = r_buf[w_idx_nxt];
        w_last_nxt   = ({1'b0, w_idx_nxt} == (w_count_nxt - 5'd1));
        w_press_code = (w_mistake_nxt && w_last_nxt) ? (w_rd_code + 2'd1) : w_rd_code;
        w_button_nxt = (w_state_nxt == c_PRESS) ? (4'b0001 << w_press_code) : 4'b0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_prev_led    <= 4'b0000;
            r_count       <= 5'd0;
            r_idx         <= 4'd0;
            r_timer       <= c_TMR_ZERO;
            r_mistake     <= 1'b0;
            r_overflow    <= 1'b0;
            r_bad_colour  <= 1'b0;
            r_button      <= 4'b0000;
            r_replay_done <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_buf[i] <= 2'd0;
            end
        end else begin
            r_state       <= w_state_nxt;
            r_prev_led    <= pad.colour_led;
            r_count       <= w_count_nxt;
            r_idx         <= w_idx_nxt;
            r_timer       <= w_timer_nxt;
            r_mistake     <= w_mistake_nxt;
            r_overflow    <= w_overflow_nxt;
            r_bad_colour  <= w_bad_nxt;
            r_button      <= w_button_nxt;
            r_replay_done <= (w_state_nxt == c_DONE) && (r_state != c_DONE);
            if (w_wr_en) begin
                r_buf[w_wr_addr] <= f_encode(pad.colour_led);
            end
        end
    end

    assign pad.button      = r_button;
    assign pad.busy        = (r_state == c_CAPTURE) || (r_state == c_PRESS) || (r_state == c_GAP);
    assign pad.seq_count   = r_count;
    assign pad.replay_done = r_replay_done;
    assign pad.overflow    = r_overflow;
    assign pad.bad_colour  = r_bad_colour;

endmodule

`default_nettype wire

// File: tb/tb_simon_autoplayer.sv
// ============================================================================
// Module      : tb_simon_autoplayer
// Description : Directed self-checking bench for simon_autoplayer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_simon_autoplayer;

    localparam int c_PRESS = 4;
    localparam int c_GAP   = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] exp_q [$];
    logic [1:0] codes [$];

    simon_autoplayer_if bus ();

    simon_autoplayer #(
        .PRESS_CYCLES (c_PRESS),
        .GAP_CYCLES   (c_GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pad (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic show(input logic [3:0] c, input int n);
        bus.colour_led = c;
        repeat (n) tick();
    endtask

    // Expected per-cycle button trace built from the colours the bench displayed
    task automatic build_expected(input logic mis);
        logic [1:0] c;
        exp_q.delete();
        for (int i = 0; i < codes.size(); i++) begin
            c = codes[i];
            if (mis && (i == codes.size() - 1)) c = c + 2'd1;
            repeat (c_PRESS) exp_q.push_back(4'b0001 << c);
            repeat (c_GAP)   exp_q.push_back(4'b0000);
        end
    endtask

    task automatic replay_check(input string tag);
        logic [3:0] e;
        int         n;
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            chk({tag, "_button"}, 32'(bus.button), 32'(e));
            tick();
        end
        chk({tag, "_done"}, 32'(bus.replay_done), 32'd1);
        chk({tag, "_idle_btn"}, 32'(bus.button), 32'd0);
    endtask

    task automatic back_to_idle();
        bus.state_dbg  = 2'b00;
        bus.colour_led = 4'b0000;
        bus.mistake    = 1'b0;
        tick();
    endtask

    initial begin
        rst            = 1'b1;
        bus.en         = 1'b0;
        bus.colour_led = 4'b0000;
        bus.state_dbg  = 2'b00;
        bus.mistake    = 1'b0;
        tick();
        tick();
        chk("rst_button", 32'(bus.button), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_count", 32'(bus.seq_count), 32'd0);
        chk("rst_done", 32'(bus.replay_done), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_bad", 32'(bus.bad_colour), 32'd0);
        rst    = 1'b0;
        bus.en = 1'b1;
        tick();

        // capture and replay
        codes.delete();
        bus.state_dbg = 2'b01;
        show(4'b0001, 3); codes.push_back(2'd0);
        show(4'b0000, 3);
        show(4'b0100, 3); codes.push_back(2'd2);
        show(4'b0000, 3);
        show(4'b1000, 3); codes.push_back(2'd3);
        chk("cap_count", 32'(bus.seq_count), 32'd3);
        chk("cap_busy", 32'(bus.busy), 32'd1);
        build_expected(1'b0);
        bus.state_dbg = 2'b10;
        tick();
        replay_check("cap");
        back_to_idle();
        chk("cap_done_pulse", 32'(bus.replay_done), 32'd0);
        chk("cap_idle_busy", 32'(bus.busy), 32'd0);

        // repeated colour separated by a blank
        codes.delete();
        bus.state_dbg = 2'b01;
        show(4'b0010, 6); codes.push_back(2'd1);
        show(4'b0000, 1);
        show(4'b0010, 3); codes.push_back(2'd1);
        chk("rep_count", 32'(bus.seq_count), 32'd2);
        build_expected(1'b0);
        bus.state_dbg = 2'b10;
        tick();
        replay_check("rep");
        back_to_idle();

        // mistake corrupts only the last press
        codes.delete();
        bus.state_dbg = 2'b01;
        show(4'b0001, 3); codes.push_back(2'd0);
        show(4'b0000, 3);
        show(4'b0100, 3); codes.push_back(2'd2);
        show(4'b0000, 3);
        show(4'b1000, 3); codes.push_back(2'd3);
        build_expected(1'b1);
        bus.state_dbg = 2'b10;
        bus.mistake   = 1'b1;
        tick();
        bus.mistake   = 1'b0;
        replay_check("mis");
        back_to_idle();

        // overflow: 17 elements, 16 kept
        codes.delete();
        bus.state_dbg = 2'b01;
        for (int i = 0; i < 17; i++) begin
            show((i % 2 == 1) ? 4'b0010 : 4'b0001, 2);
            if (i < 16) codes.push_back((i % 2 == 1) ? 2'd1 : 2'd0);
        end
        chk("ovf_count", 32'(bus.seq_count), 32'd16);
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        build_expected(1'b0);
        bus.state_dbg = 2'b10;
        tick();
        replay_check("ovf");
        back_to_idle();
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);

        // bad colour, then enable drop mid-capture
        bus.state_dbg = 2'b01;
        show(4'b0100, 2);
        chk("bad_ovf_clr", 32'(bus.overflow), 32'd0);
        show(4'b0011, 2);
        chk("bad_flag", 32'(bus.bad_colour), 32'd1);
        chk("bad_count", 32'(bus.seq_count), 32'd1);
        show(4'b0000, 1);
        bus.en = 1'b0;
        tick();
        chk("en_busy", 32'(bus.busy), 32'd0);
        chk("en_count", 32'(bus.seq_count), 32'd1);
        chk("en_bad", 32'(bus.bad_colour), 32'd1);
        chk("en_button", 32'(bus.button), 32'd0);
        bus.en        = 1'b1;
        bus.state_dbg = 2'b00;
        tick();
        chk("en_idle_busy", 32'(bus.busy), 32'd0);

        // abort mid-press
        bus.state_dbg = 2'b01;
        show(4'b1000, 2);
        show(4'b0000, 1);
        chk("abt_bad_clr", 32'(bus.bad_colour), 32'd0);
        bus.state_dbg = 2'b10;
        tick();
        chk("abt_press0", 32'(bus.button), 32'h8);
        tick();
        chk("abt_press1", 32'(bus.button), 32'h8);
        bus.state_dbg = 2'b11;
        tick();
        chk("abt_button", 32'(bus.button), 32'd0);
        chk("abt_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("abt_stay_idle", 32'(bus.busy), 32'd0);
        back_to_idle();

        // asynchronous reset between edges during PRESS
        bus.state_dbg = 2'b01;
        show(4'b0100, 2);
        show(4'b0011, 1);
        show(4'b0000, 1);
        chk("ar_bad_pre", 32'(bus.bad_colour), 32'd1);
        bus.state_dbg = 2'b10;
        tick();
        chk("ar_press", 32'(bus.button), 32'h4);
        #2 rst = 1'b1;
        #1;
        chk("ar_button", 32'(bus.button), 32'd0);
        chk("ar_busy", 32'(bus.busy), 32'd0);
        chk("ar_count", 32'(bus.seq_count), 32'd0);
        chk("ar_bad", 32'(bus.bad_colour), 32'd0);
        chk("ar_ovf", 32'(bus.overflow), 32'd0);
        chk("ar_done", 32'(bus.replay_done), 32'd0);
        #1 rst = 1'b0;
        tick();
        chk("ar_after_button", 32'(bus.button), 32'd0);
        chk("ar_after_busy", 32'(bus.busy), 32'd0);
        back_to_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
